// File: rtl/pwm_bank.sv
// pwm_bank: bank of CHANNELS PWM / tone timers behind a simple register bus.
//   raw_clk                 sole clock, rising edge
//   reset_n                 synchronous active-low reset
//   enable, write_enable    bus access strobe / direction (1 = write)
//   address[5:0]            channel n at 4*n (+0 period, +1 duty, +2 control,
//                           +3 count RO); 0x3c flags (W1C); 0x3d global (bit0 sync)
//   data_in[15:0]           write data, bits above WIDTH ignored
//   data_out[15:0]          registered read data, zero-extended
//   ready                   one-cycle ack, the cycle after each access
//   pwm_out[CHANNELS-1:0]   per-channel waveform
//   irq                     registered OR of flag & irq_en

// pwm_chan: one timer lane. Holds shadow/active period and duty, control,
// counter, tone bit and wrap flag; produces that lane's waveform.
//   clk, rst_n              clock, synchronous active-low reset
//   wr_period/duty/ctrl     decoded register write strobes, data on wdata
//   sync                    global sync: zero counter/tone, load shadows
//   flag_clr                W1C clear of this lane's flag
//   period_sh, duty_sh,
//   ctrl, count, flag       readback state
//   pwm                     waveform after invert
module pwm_chan #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] wdata,
  input  logic             sync,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] period_sh,
  output logic [WIDTH-1:0] duty_sh,
  output logic [3:0]       ctrl,
  output logic [WIDTH-1:0] count,
  output logic             flag,
  output logic             pwm
);
  logic [WIDTH-1:0] period_act, duty_act;
  logic             tone, active, start, mode_chg, restart, wrap;

  // ctrl: [0] run, [1] mode (1 = tone), [2] invert, [3] irq_en
  assign active   = ctrl[0] && (period_act != '0);
  assign start    = wr_ctrl && wdata[0] && !ctrl[0];
  assign mode_chg = wr_ctrl && (wdata[1] != ctrl[1]);
  // Anything that restarts the counter also suppresses a coincident wrap.
  assign restart  = sync || start || mode_chg;
  assign wrap     = active && (count == period_act) && !restart;
  assign pwm      = (active && (ctrl[1] ? tone : (count < duty_act))) ^ ctrl[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_sh  <= '0;
      duty_sh    <= '0;
      period_act <= '0;
      duty_act   <= '0;
      ctrl       <= '0;
      count      <= '0;
      tone       <= 1'b0;
      flag       <= 1'b0;
    end else begin
      if (wr_period) period_sh <= wdata;
      if (wr_duty)   duty_sh   <= wdata;
      if (wr_ctrl)   ctrl      <= wdata[3:0];
      if (sync || start || wrap) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end
      if (restart || !active) begin
        count <= '0;
        tone  <= 1'b0;
      end else if (wrap) begin
        count <= '0;
        tone  <= tone ^ ctrl[1];
      end else begin
        count <= count + WIDTH'(1);
      end
      // wrap wins over a same-edge W1C
      flag <= (flag && !flag_clr) || wrap;
    end
  end
endmodule

module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                raw_clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                write_enable,
  input  logic [5:0]          address,
  input  logic [15:0]         data_in,
  output logic [15:0]         data_out,
  output logic                ready,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);
  localparam logic [4:0] CH_LIM = 5'(CHANNELS);

  logic                               acc_wr, acc_rd, chan_hit, sync;
  logic [3:0]                         ch_sel;
  logic [1:0]                         reg_sel;
  logic [CHANNELS-1:0][WIDTH-1:0]     period_sh, duty_sh, count;
  logic [CHANNELS-1:0][3:0]           ctrl;
  logic [CHANNELS-1:0]                flag, irq_en;
  logic [15:0]                        rdata;

  assign acc_wr   = enable && write_enable;
  assign acc_rd   = enable && !write_enable;
  assign ch_sel   = address[5:2];
  assign reg_sel  = address[1:0];
  // 0x3c/0x3d decode to ch_sel 15, so they never alias a channel.
  assign chan_hit = {1'b0, ch_sel} < CH_LIM;
  assign sync     = acc_wr && (address == 6'h3d) && data_in[0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_chan #(.WIDTH(WIDTH)) u_ch (
      .clk       (raw_clk),
      .rst_n     (reset_n),
      .wr_period (acc_wr && chan_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd0)),
      .wr_duty   (acc_wr && chan_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd1)),
      .wr_ctrl   (acc_wr && chan_hit && (ch_sel == 4'(i)) && (reg_sel == 2'd2)),
      .wdata     (data_in[WIDTH-1:0]),
      .sync      (sync),
      .flag_clr  (acc_wr && (address == 6'h3c) && data_in[i]),
      .period_sh (period_sh[i]),
      .duty_sh   (duty_sh[i]),
      .ctrl      (ctrl[i]),
      .count     (count[i]),
      .flag      (flag[i]),
      .pwm       (pwm_out[i])
    );
    assign irq_en[i] = ctrl[i][3];
  end

  always_comb begin
    rdata = '0;
    if (address == 6'h3c) rdata = 16'(flag);
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_hit && (ch_sel == 4'(i))) begin
        case (reg_sel)
          2'd0:    rdata = 16'(period_sh[i]);
          2'd1:    rdata = 16'(duty_sh[i]);
          2'd2:    rdata = 16'(ctrl[i]);
          default: rdata = 16'(count[i]);
        endcase
      end
    end
  end

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      data_out <= '0;
      ready    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ready <= enable;
      if (acc_rd) data_out <= rdata;
      irq <= |(flag & irq_en);
    end
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed scenarios plus randomized channel setups,
// waveforms predicted from period/duty arithmetic, registers from written values.
module tb_pwm_bank;
  localparam int CH = 4;
  localparam int W  = 16;

  logic          raw_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          write_enable = 1'b0;
  logic [5:0]    address = '0;
  logic [15:0]   data_in = '0;
  logic [15:0]   data_out;
  logic          ready;
  logic [CH-1:0] pwm_out;
  logic          irq;

  int vectors = 0;
  int errors  = 0;
  int k       = 0;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .raw_clk      (raw_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .ready        (ready),
    .pwm_out      (pwm_out),
    .irq          (irq)
  );

  always #5 raw_clk = ~raw_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Expected waveform k cycles after a channel (re)start with period p, duty d.
  function automatic logic exp_wave(int p, int d, bit mode, bit inv, int kk);
    logic raw;
    if (p == 0)    raw = 1'b0;
    else if (mode) raw = ((kk / (p + 1)) % 2) == 1;
    else           raw = (kk % (p + 1)) < d;
    return raw ^ inv;
  endfunction

  task automatic tick();
    @(posedge raw_clk); #1;
    k++;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    tick();
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a);
    enable = 1'b1; write_enable = 1'b0; address = a;
    tick();
    enable = 1'b0;
  endtask

  task automatic stop_all();
    for (int c = 0; c < CH; c++) bus_write(6'(c * 4 + 2), 16'h0);
    bus_write(6'h3c, 16'hffff);
    tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b1; write_enable = 1'b1; address = 6'h00; data_in = 16'h1234;
    tick(); tick();
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
    vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h exp 0000", data_out); end
    vectors++; if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm: got %b exp 0", pwm_out); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
    enable = 1'b0; write_enable = 1'b0; reset_n = 1'b1;
    tick();
    bus_read(6'h00);
    vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_dropped_write: got %h exp 0000", data_out); end
  endtask

  task automatic test_pwm_basic();
    bus_write(6'h00, 16'd9);
    bus_write(6'h01, 16'd3);
    bus_write(6'h02, 16'h1);
    k = 0;
    for (int n = 0; n < 30; n++) begin
      vectors++;
      if (pwm_out[0] !== exp_wave(9, 3, 0, 0, k)) begin
        errors++; $display("FAIL pwm_basic k=%0d: got %b exp %b", k, pwm_out[0], exp_wave(9, 3, 0, 0, k));
      end
      tick();
    end
  endtask

  task automatic test_tone_irq();
    stop_all();
    bus_write(6'h04, 16'd4);
    bus_write(6'h06, 16'hb);  // run | tone | irq_en
    k = 0;
    for (int n = 0; n <= 6; n++) begin
      vectors++;
      if (pwm_out[1] !== exp_wave(4, 0, 1, 0, k)) begin
        errors++; $display("FAIL tone k=%0d: got %b exp %b", k, pwm_out[1], exp_wave(4, 0, 1, 0, k));
      end
      vectors++;
      if (irq !== (k >= 6)) begin
        errors++; $display("FAIL tone_irq k=%0d: got %b exp %b", k, irq, (k >= 6));
      end
      if (n != 6) tick();
    end
    bus_write(6'h3c, 16'h2);
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold k=%0d: got %b exp 1", k, irq); end
    tick();
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear k=%0d: got %b exp 0", k, irq); end
    vectors++;
    if (pwm_out[1] !== exp_wave(4, 0, 1, 0, k)) begin
      errors++; $display("FAIL tone k=%0d: got %b exp %b", k, pwm_out[1], exp_wave(4, 0, 1, 0, k));
    end
    while (k < 11) tick();
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rewrap k=%0d: got %b exp 1", k, irq); end
  endtask

  task automatic test_duty_update();
    logic e;
    stop_all();
    bus_write(6'h00, 16'd9);
    bus_write(6'h01, 16'd3);
    bus_write(6'h02, 16'h1);
    k = 0;
    while (k < 20) begin
      e = (k < 10) ? exp_wave(9, 3, 0, 0, k) : exp_wave(9, 8, 0, 0, k);
      vectors++;
      if (pwm_out[0] !== e) begin
        errors++; $display("FAIL duty_update k=%0d: got %b exp %b", k, pwm_out[0], e);
      end
      if (k == 2) bus_write(6'h01, 16'd8);
      else tick();
    end
    bus_read(6'h01);
    vectors++; if (data_out !== 16'd8) begin errors++; $display("FAIL duty_shadow_read: got %0d exp 8", data_out); end
  endtask

  task automatic test_back_to_back();
    stop_all();
    enable = 1'b1; write_enable = 1'b1; address = 6'h00; data_in = 16'd6;
    tick();
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w0: got %b exp 1", ready); end
    address = 6'h04; data_in = 16'd128;
    tick();
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w1: got %b exp 1", ready); end
    enable = 1'b0; write_enable = 1'b0;
    tick();
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_idle: got %b exp 0", ready); end
    enable = 1'b1; address = 6'h00;
    tick();
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_r0: got %b exp 1", ready); end
    vectors++; if (data_out !== 16'd6) begin errors++; $display("FAIL b2b_read0: got %0d exp 6", data_out); end
    address = 6'h04;
    tick();
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_r1: got %b exp 1", ready); end
    vectors++; if (data_out !== 16'd128) begin errors++; $display("FAIL b2b_read1: got %0d exp 128", data_out); end
    enable = 1'b0;
    tick();
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_end: got %b exp 0", ready); end
    vectors++; if (data_out !== 16'd128) begin errors++; $display("FAIL b2b_hold: got %0d exp 128", data_out); end
  endtask

  task automatic test_boundaries();
    stop_all();
    bus_write(6'h08, 16'd9);
    bus_write(6'h09, 16'd0);
    bus_write(6'h0a, 16'h1);
    for (int n = 0; n < 20; n++) begin
      vectors++; if (pwm_out[2] !== 1'b0) begin errors++; $display("FAIL duty0 k=%0d: got %b exp 0", n, pwm_out[2]); end
      tick();
    end
    bus_write(6'h09, 16'd10);
    bus_write(6'h3d, 16'h1);   // global sync: load duty 10 now
    k = 0;
    for (int n = 0; n < 20; n++) begin
      vectors++;
      if (pwm_out[2] !== exp_wave(9, 10, 0, 0, k)) begin
        errors++; $display("FAIL duty_full k=%0d: got %b exp %b", k, pwm_out[2], exp_wave(9, 10, 0, 0, k));
      end
      tick();
    end
    bus_write(6'h0a, 16'hfff5);  // run | invert, junk in upper bits
    for (int n = 0; n < 20; n++) begin
      vectors++;
      if (pwm_out[2] !== exp_wave(9, 10, 0, 1, k)) begin
        errors++; $display("FAIL invert k=%0d: got %b exp %b", k, pwm_out[2], exp_wave(9, 10, 0, 1, k));
      end
      tick();
    end
    while (k < 49) tick();
    bus_write(6'h3c, 16'h4);   // lands on the wrap edge into k=50
    bus_read(6'h3c);
    vectors++; if (data_out !== 16'h4) begin errors++; $display("FAIL w1c_on_wrap: got %h exp 0004", data_out); end
    bus_write(6'h3c, 16'h4);
    bus_read(6'h3c);
    vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL w1c_clear: got %h exp 0000", data_out); end
    bus_read(6'h3d);
    vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL global_read: got %h exp 0000", data_out); end
    bus_read(6'h0a);
    vectors++; if (data_out !== 16'h5) begin errors++; $display("FAIL ctrl_read: got %h exp 0005", data_out); end
  endtask

  task automatic test_random();
    int ch, p, d, kk, ua;
    bit mode, inv;
    logic [5:0] base;
    logic [CH-1:0] ev;
    logic [15:0] ec;
    for (int it = 0; it < 12; it++) begin
      stop_all();
      ch   = $urandom_range(0, CH - 1);
      p    = $urandom_range(0, 20);
      d    = $urandom_range(0, p + 2);
      mode = 1'($urandom_range(0, 1));
      inv  = 1'($urandom_range(0, 1));
      base = 6'(ch * 4);
      bus_write(base + 6'd3, 16'hffff);
      bus_read(base + 6'd3);
      vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL count_ro ch%0d: got %h exp 0000", ch, data_out); end
      bus_write(base, 16'(p));
      bus_write(base + 6'd1, 16'(d));
      bus_write(base + 6'd2, {13'b0, inv, mode, 1'b1});
      k = 0;
      for (int n = 0; n < 2 * (p + 1) + 4; n++) begin
        ev = '0;
        ev[ch] = exp_wave(p, d, mode, inv, k);
        vectors++;
        if (pwm_out !== ev) begin
          errors++; $display("FAIL rand_wave ch%0d p=%0d d=%0d m=%0d i=%0d k=%0d: got %b exp %b", ch, p, d, mode, inv, k, pwm_out, ev);
        end
        tick();
      end
      kk = k;
      bus_read(base + 6'd3);
      ec = (p == 0) ? 16'h0 : 16'(kk % (p + 1));
      vectors++; if (data_out !== ec) begin errors++; $display("FAIL rand_count ch%0d: got %0d exp %0d", ch, data_out, ec); end
      bus_read(base);
      vectors++; if (data_out !== 16'(p)) begin errors++; $display("FAIL rand_period ch%0d: got %0d exp %0d", ch, data_out, p); end
      bus_read(base + 6'd1);
      vectors++; if (data_out !== 16'(d)) begin errors++; $display("FAIL rand_duty ch%0d: got %0d exp %0d", ch, data_out, d); end
      bus_read(base + 6'd2);
      ec = {13'b0, inv, mode, 1'b1};
      vectors++; if (data_out !== ec) begin errors++; $display("FAIL rand_ctrl ch%0d: got %h exp %h", ch, data_out, ec); end
      ua = $urandom_range(16, 59);
      bus_write(6'(ua), 16'($urandom));
      bus_read(6'(ua));
      vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL unmapped %h: got %h exp 0000", ua, data_out); end
    end
  endtask

  task automatic test_reset_midrun();
    stop_all();
    bus_write(6'h00, 16'd9);
    bus_write(6'h01, 16'd5);
    bus_write(6'h02, 16'h1);
    bus_write(6'h06, 16'h4);   // ch1 idle but inverted -> output high
    repeat (4) tick();
    reset_n = 1'b0;
    enable = 1'b1; write_enable = 1'b1; address = 6'h01; data_in = 16'd7;
    tick();
    reset_n = 1'b1; enable = 1'b0; write_enable = 1'b0;
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL midrun_ready: got %b exp 0", ready); end
    vectors++; if (pwm_out !== '0) begin errors++; $display("FAIL midrun_pwm: got %b exp 0", pwm_out); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_irq: got %b exp 0", irq); end
    for (int a = 0; a <= 'h3d; a++) begin
      bus_read(6'(a));
      vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL midrun_read %h: got %h exp 0000", a, data_out); end
    end
    vectors++; if (pwm_out !== '0) begin errors++; $display("FAIL midrun_pwm_after: got %b exp 0", pwm_out); end
  endtask

  initial begin
    test_reset();
    test_pwm_basic();
    test_tone_irq();
    test_duty_update();
    test_back_to_back();
    test_boundaries();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
